// File: rtl/light_bcd_disp_drv.sv
// Multiplexed two-digit 7-segment driver for the traffic-light BCD countdown.
// Blanks a leading zero, blinks near the end of the count, flags bad BCD and pulses on expiry.
module light_bcd_disp_drv #(
  parameter int unsigned SCAN_DIV  = 4,
  parameter int unsigned BLINK_TH  = 3,
  parameter int unsigned BLINK_DIV = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [7:0] cnt,
  output logic [6:0] seg,
  output logic [1:0] dig_sel,
  output logic       expire,
  output logic       err
);

  localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned BW = $clog2(2 * BLINK_DIV);

  typedef enum logic {DIG_ONES, DIG_TENS} digit_e;

  logic [7:0]    cnt_q;
  logic          en_q;
  logic [SW-1:0] scan_cnt;
  digit_e        digit;
  logic [BW-1:0] blink_cnt;

  logic [3:0] tens_q, ones_q;
  logic       in_blink, blink_off, cnt_illegal;
  logic [6:0] seg_nxt;
  logic [1:0] dig_sel_nxt;

  function automatic logic [6:0] decode(input logic [3:0] nib);
    case (nib)
      4'd0:    decode = 7'h3F;
      4'd1:    decode = 7'h06;
      4'd2:    decode = 7'h5B;
      4'd3:    decode = 7'h4F;
      4'd4:    decode = 7'h66;
      4'd5:    decode = 7'h6D;
      4'd6:    decode = 7'h7D;
      4'd7:    decode = 7'h07;
      4'd8:    decode = 7'h7F;
      4'd9:    decode = 7'h6F;
      default: decode = 7'h79;
    endcase
  endfunction

  assign tens_q      = cnt_q[7:4];
  assign ones_q      = cnt_q[3:0];
  assign in_blink    = (tens_q == 4'd0) && (ones_q != 4'd0) && (ones_q <= 4'(BLINK_TH));
  // Gated by in_blink so a stale off-phase count never blanks a value that left the region.
  assign blink_off   = in_blink && (blink_cnt >= BW'(BLINK_DIV));
  assign cnt_illegal = (cnt[7:6] != 2'b00) || (cnt[3:0] > 4'd9);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    seg_nxt     = 7'h00;
    dig_sel_nxt = (digit == DIG_ONES) ? 2'b01 : 2'b10;
    if (en_q && !blink_off) begin
      if (digit == DIG_ONES)
        seg_nxt = decode(ones_q);
      else if (tens_q[3:2] != 2'b00)
        seg_nxt = 7'h79;
      else if (tens_q != 4'd0)
        seg_nxt = decode(tens_q);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q     <= 8'h00;
      en_q      <= 1'b0;
      scan_cnt  <= '0;
      digit     <= DIG_ONES;
      blink_cnt <= '0;
      seg       <= 7'h00;
      dig_sel   <= 2'b00;
      expire    <= 1'b0;
      err       <= 1'b0;
    end else begin
      cnt_q   <= enable ? cnt : 8'h00;
      en_q    <= enable;
      seg     <= seg_nxt;
      dig_sel <= dig_sel_nxt;
      expire  <= enable && (cnt_q != 8'h00) && (cnt == 8'h00);
      err     <= err || (enable && cnt_illegal);

      if (scan_cnt == SW'(SCAN_DIV - 1)) begin
        scan_cnt <= '0;
        digit    <= (digit == DIG_ONES) ? DIG_TENS : DIG_ONES;
      end else begin
        scan_cnt <= scan_cnt + SW'(1);
      end

      if (!in_blink)
        blink_cnt <= '0;
      else if (blink_cnt == BW'(2 * BLINK_DIV - 1))
        blink_cnt <= '0;
      else
        blink_cnt <= blink_cnt + BW'(1);
    end
  end

endmodule
